// File: rtl/cpu_pkg.sv
// Shared CPU constants for the writeback/register-file slice.
package cpu_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/wb_regfile_if.sv
// Writeback and decode-port bundle between the pipeline (master) and the register file (slave).
interface wb_regfile_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);
    logic              MemToReg;
    logic              RegWrite;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] write_reg;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       wb_count;

    modport master (
        output MemToReg, RegWrite, read_data, alu_result, write_reg, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_count
    );

    modport slave (
        input  MemToReg, RegWrite, read_data, alu_result, write_reg, rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_count
    );
endinterface

// File: rtl/wb_regfile_mux.sv
// Writeback source select: load data when MemToReg is set, otherwise the ALU result.
module wb_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              MemToReg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] wb_data
);
    assign wb_data = MemToReg ? read_data : alu_result;
endmodule

// File: rtl/wb_regfile.sv
// Register file with writeback mux, hard-wired r0 and a commit counter.
// Define WB_BYPASS_EN to let read ports see the value being written in the same cycle.
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    import cpu_pkg::*;

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [31:0]       count_q, count_d;
    logic              armed_q;
    logic [DATA_W-1:0] wbData;
    logic              commitEn;
    logic [DATA_W-1:0] rsData, rtData;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .MemToReg   (bus.MemToReg),
        .read_data  (bus.read_data),
        .alu_result (bus.alu_result),
        .wb_data    (wbData)
    );

    // armed_q stays low through the first edge after reset so a write pending
    // as reset releases is dropped rather than racing the release.
    assign commitEn = bus.RegWrite && (bus.write_reg != ZERO_IDX) && armed_q && !reset;

    always_comb begin
        count_d = count_q;
        if (commitEn) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            count_q <= count_d;
            if (commitEn) begin
                regs_q[bus.write_reg] <= wbData;
            end
        end
    end

    always_comb begin
        rsData = '0;
        if (reset || bus.rs_addr == ZERO_IDX) begin
            rsData = '0;
        end
`ifdef WB_BYPASS_EN
        else if (commitEn && bus.rs_addr == bus.write_reg) begin
            rsData = wbData;
        end
`endif
        else begin
            rsData = regs_q[bus.rs_addr];
        end
    end

    always_comb begin
        rtData = '0;
        if (reset || bus.rt_addr == ZERO_IDX) begin
            rtData = '0;
        end
`ifdef WB_BYPASS_EN
        else if (commitEn && bus.rt_addr == bus.write_reg) begin
            rtData = wbData;
        end
`endif
        else begin
            rtData = regs_q[bus.rt_addr];
        end
    end

    assign bus.rs_data  = rsData;
    assign bus.rt_data  = rtData;
    assign bus.wb_data  = wbData;
    assign bus.wb_count = count_q;
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register and data width.
REQ-002 Parameter ADDR_W, default 5, register index width; register count is 2**ADDR_W.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemToReg  input  1  writeback source select from the MEM/WB stage: 1 selects load data, 0 selects ALU result.
REQ-006 RegWrite  input  1  writeback enable from the MEM/WB stage.
REQ-007 read_data  input  DATA_W  load data from the MEM/WB stage.
REQ-008 alu_result  input  DATA_W  ALU result from the MEM/WB stage.
REQ-009 write_reg  input  ADDR_W  destination register index.
REQ-010 rs_addr, rt_addr  input  ADDR_W each  decode-stage read indices.
REQ-011 rs_data, rt_data  output  DATA_W each  read-port data.
REQ-012 wb_data  output  DATA_W  selected writeback value, combinational, for external forwarding.
REQ-013 wb_count  output  32  count of committed register writes.

Function
REQ-014 wb_data SHALL equal read_data when MemToReg=1, else alu_result, regardless of RegWrite.
REQ-015 A commit SHALL occur on a rising clk when RegWrite=1 and write_reg!=0: regs[write_reg] <= wb_data.
REQ-016 Register 0 SHALL read as 0 always; writes to index 0 SHALL be discarded and SHALL NOT count as a commit.
REQ-017 Read ports SHALL be combinational from the array; rs and rt SHALL be independent, and both may address the same index.
REQ-018 When RegWrite=1, write_reg!=0 and the read index equals write_reg in the same cycle, the port SHALL return wb_data (write-through), subject to REQ-026.
REQ-019 wb_count SHALL increment by 1 per commit, registered, wrapping from 0xFFFFFFFF to 0 with no flag.
REQ-020 Write latency SHALL be one clock: a committed value is visible from the array on the cycle after the edge.
REQ-021 X on MemToReg SHALL NOT corrupt any register when RegWrite=0.

Reset
REQ-022 Asserting reset SHALL immediately clear all registers and wb_count to 0, independent of clk.
REQ-023 While reset is high, no commit SHALL occur, and rs_data and rt_data SHALL read 0 (bypass suppressed).
REQ-024 A write pending on the edge where reset deasserts SHALL NOT commit; the first commit occurs on the next edge.

Configuration
REQ-025 Macro WB_BYPASS_EN SHALL, when defined, enable the write-through path of REQ-018.
REQ-026 Without WB_BYPASS_EN, read ports SHALL return the pre-write array value in the write cycle; the pipeline then relies on an external hazard stall. Without WB_BYPASS_EN, REQ-014 through REQ-024 still hold, apart from the write-through behaviour of REQ-018.

Structure
REQ-027 Package cpu_pkg SHALL hold DATA_W and ADDR_W defaults and the constant REG_ZERO=0.
REQ-028 The writeback select SHALL be a sub-module wb_mux (MemToReg, read_data, alu_result -> wb_data); the array, bypass and counter SHALL reside in wb_regfile.

Verification
REQ-029 Reset mid-run after writing r5=0x1234 -> rs_addr=5 reads 0 immediately and wb_count=0.
REQ-030 RegWrite=1, MemToReg=1, read_data=0xDEADBEEF, write_reg=7, one edge -> rs_addr=7 reads 0xDEADBEEF and wb_count=1.
REQ-031 RegWrite=1, write_reg=0, alu_result=0xFFFFFFFF -> rt_addr=0 reads 0 and wb_count is unchanged.
REQ-032 Same cycle: write r9=0xA5A5A5A5 with rs_addr=rt_addr=9 -> both ports read 0xA5A5A5A5 with WB_BYPASS_EN defined, or the old value without it; both read 0xA5A5A5A5 on the next cycle.
REQ-033 RegWrite=0, MemToReg=X, write_reg=3 -> r3 unchanged and wb_count unchanged.
REQ-034 Preload wb_count to 0xFFFFFFFF via commits or a force, then one commit -> wb_count=0.
